// File: rtl/mult_seq.sv
// -----------------------------------------------------------------------------
// mult_seq -- sequential shift-and-add unsigned multiplier
//
// Computes P = A * B one multiplier bit at a time, MSB first. Uses the same
// start/idle/finish handshake, zero-operand shortcut and bit iteration order as
// the restoring-division unit, so both can sit behind one issue path.
//
// A top FSM sequences the job: IDLE -> CHECK -> CALC -> FINI -> IDLE.
// While in CALC, an inner FSM walks each multiplier bit:
//   SHIFT -> TEST -> [ADD] -> NEXT
// A set bit costs 4 cycles and a clear bit costs 3.
//
// Ports
//   CLK     in   1         clock, all state updates on the rising edge
//   reset   in   1         synchronous, active-high reset
//   start   in   1         job request, sampled only in IDLE
//   A       in   WIDTH     multiplicand, captured when start is accepted
//   B       in   WIDTH     multiplier, captured when start is accepted
//   P       out  2*WIDTH   product register, updated on the edge entering FINI
//   idle    out  1         high only in IDLE
//   finish  out  1         high only in FINI (one cycle per job)
// -----------------------------------------------------------------------------
module mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   P,
  output logic                 idle,
  output logic                 finish
);

  localparam int              IW     = $clog2(WIDTH);
  localparam logic [IW-1:0]   I_LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_CALC,
    S_FINI
  } top_state_t;

  typedef enum logic [1:0] {
    C_SHIFT,
    C_TEST,
    C_ADD,
    C_NEXT
  } calc_state_t;

  top_state_t   state, state_nxt;
  calc_state_t  calc, calc_nxt;

  logic [WIDTH-1:0]   A_r;
  logic [WIDTH-1:0]   B_r;
  logic [2*WIDTH-1:0] acc;
  logic [IW-1:0]      i;

  // Datapath control strobes, decoded from the FSM state.
  logic ld_job;     // capture operands and clear the accumulator
  logic do_shift;   // acc <= acc << 1
  logic do_add;     // acc <= acc + A_r
  logic dec_i;      // advance to the next lower multiplier bit
  logic reload_i;   // restore the bit index for the next job
  logic ld_p;       // publish acc into the product register

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= S_IDLE;
      calc  <= C_SHIFT;
    end else begin
      state <= state_nxt;
      calc  <= calc_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that left one
  // unassigned would make synthesis hold its old value with a latch.
  always_comb begin
    state_nxt = state;
    calc_nxt  = C_SHIFT;   // inner FSM parks in SHIFT outside CALC
    ld_job    = 1'b0;
    do_shift  = 1'b0;
    do_add    = 1'b0;
    dec_i     = 1'b0;
    reload_i  = 1'b0;
    ld_p      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          ld_job    = 1'b1;
          state_nxt = S_CHECK;
        end
      end

      S_CHECK: begin
        // A zero operand skips the bit loop. acc was cleared at issue, so
        // publishing it yields the zero product directly.
        if (A_r == '0 || B_r == '0) begin
          state_nxt = S_FINI;
          ld_p      = 1'b1;
        end else begin
          state_nxt = S_CALC;
        end
      end

      S_CALC: begin
        unique case (calc)
          C_SHIFT: begin
            do_shift = 1'b1;
            calc_nxt = C_TEST;
          end

          C_TEST: begin
            calc_nxt = B_r[i] ? C_ADD : C_NEXT;
          end

          C_ADD: begin
            do_add   = 1'b1;
            calc_nxt = C_NEXT;
          end

          C_NEXT: begin
            if (i == '0) begin
              state_nxt = S_FINI;
              ld_p      = 1'b1;
            end else begin
              dec_i    = 1'b1;
              calc_nxt = C_SHIFT;
            end
          end

          default: calc_nxt = C_SHIFT;
        endcase
      end

      S_FINI: begin
        reload_i  = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // The strobes are mutually exclusive by construction, so the order of the
  // if statements below carries no priority meaning.
  always_ff @(posedge CLK) begin
    if (reset) begin
      A_r <= '0;
      B_r <= '0;
      acc <= '0;
      i   <= I_LAST;
      P   <= '0;
    end else begin
      if (ld_job) begin
        A_r <= A;
        B_r <= B;
        acc <= '0;
        i   <= I_LAST;
      end

      // MSB-first iteration: shift before each bit. The top bit never carries
      // data for in-range operands, so discarding it loses nothing.
      if (do_shift) begin
        acc <= {acc[2*WIDTH-2:0], 1'b0};
      end

      if (do_add) begin
        acc <= acc + {{WIDTH{1'b0}}, A_r};
      end

      if (dec_i) begin
        i <= i - IW'(1);
      end

      if (reload_i) begin
        i <= I_LAST;
      end

      // P changes only when a job completes and holds through the next job.
      if (ld_p) begin
        P <= acc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  assign idle   = (state == S_IDLE);
  assign finish = (state == S_FINI);

endmodule
